// File: rtl/mux_n_input_stream.sv
// -----------------------------------------------------------------------------
// mux_n_input_stream
//
// Packet-aware N:1 stream multiplexer with a one-beat registered output stage.
// A channel is granted either by the `sel` input (MODE=0) or by a round-robin
// search starting after the channel that last completed a packet (MODE=1).
// Once the first beat of a multi-beat packet has been accepted, the grant is
// locked to that channel until its last beat is transferred, so packets from
// different channels never interleave on the output.
//
// Handshake: a beat moves across a port on a rising clk edge where that
// port's valid and ready are both 1. Valid does not wait for ready, and ready
// may be high while valid is low. Only the granted channel can see ready=1.
// The output register can accept a new beat when it is empty or is being
// popped in the same cycle. This gives one beat per cycle at full throughput.
//
// Ports
//   clk        in   1        clock, rising-edge
//   reset_n    in   1        synchronous active-low reset
//   in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel beat valid
//   in_last    in   N        per-channel last beat of packet
//   in_ready   out  N        per-channel ready (one-hot or zero)
//   sel        in   SW       requested channel (MODE=0 only)
//   out_data   out  WIDTH    registered beat data
//   out_last   out  1        registered last flag
//   out_chan   out  SW       source channel of the held beat
//   out_valid  out  1        output register holds a beat
//   out_ready  in   1        downstream accepts the held beat
//   dbg_state  out  1        FSM state (0 = IDLE, 1 = LOCKED)
// -----------------------------------------------------------------------------
module mux_n_input_stream #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SW-1:0]      out_chan,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    lock_chan_q, lock_chan_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SW-1:0]    out_chan_q, out_chan_d;

    logic             grant_valid;
    logic [SW-1:0]    grant_chan;
    logic             can_load;
    logic             xfer;
    logic             pop;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;

    // -------------------------------------------------------------------------
    // Grant selection. LOCKED always wins so a packet in flight cannot be
    // interrupted by sel changes or by other channels becoming valid.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_chan  = '0;
        if (state_q == LOCKED) begin
            grant_valid = 1'b1;
            grant_chan  = lock_chan_q;
        end else if (MODE == 0) begin
            // When N is not a power of two, sel can encode a non-existent channel.
            if (32'(sel) < N) begin
                grant_valid = 1'b1;
                grant_chan  = sel;
            end
        end else begin
            // Walk from the farthest candidate (ptr+N) down to the nearest
            // (ptr+1). The nearest valid channel is written last, so it wins
            // without a break or a found flag.
            for (int k = N; k >= 1; k--) begin
                logic [SW-1:0] cand;
                cand = SW'((int'(ptr_q) + k) % N);
                if (in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_chan  = cand;
                end
            end
        end
    end

    // Ready depends only on our own state, sel/in_valid and out_ready.
    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        if (reset_n && grant_valid && can_load) begin
            in_ready[grant_chan] = 1'b1;
        end
    end

    assign xfer       = |(in_ready & in_valid);
    assign pop        = out_valid_q && out_ready;
    assign grant_data = in_data[int'(grant_chan)*WIDTH +: WIDTH];
    assign grant_last = in_last[grant_chan];

    // -------------------------------------------------------------------------
    // Output register next state. A load has priority over a pop, because a
    // load in the same cycle as a pop replaces the beat that leaves.
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_last_d  = grant_last;
            out_chan_d  = grant_chan;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Packet lock FSM and round-robin pointer.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer && !grant_last) begin
                    state_d     = LOCKED;
                    lock_chan_d = grant_chan;
                end
            end
            LOCKED: begin
                if (xfer && grant_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The pointer marks the channel that finished most recently. The next
        // search therefore starts just past it.
        if (MODE == 1 && xfer && grant_last) begin
            ptr_d = grant_chan;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lock_chan_q <= '0;
            ptr_q       <= SW'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;
    assign dbg_state = (state_q == LOCKED);

endmodule

// File: tb/tb_mux_n_input_stream.sv
// -----------------------------------------------------------------------------
// Bench for mux_n_input_stream. It drives three instances side by side:
//   k=0 : MODE=0, N=4, WIDTH=4  (sel driven)
//   k=1 : MODE=1, N=4, WIDTH=4  (round robin)
//   k=2 : MODE=0, N=5, WIDTH=4  (sel can encode a missing channel)
// A packet-level reference model tracks each instance. It records the held
// beat, the locked channel (-1 when free) and the last finished channel.
// Directed scenarios come first, followed by randomized traffic with random
// resets.
// -----------------------------------------------------------------------------
module tb_mux_n_input_stream;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- stimulus (per instance, sized for the largest) ----------
    logic [4:0]  v_i    [3];
    logic [4:0]  l_i    [3];
    logic [19:0] d_i    [3];
    logic [2:0]  s_i    [3];
    logic        ordy_i [3];

    // ---------------- observed outputs ----------------
    logic [4:0] obs_rdy [3];
    logic [3:0] obs_od  [3];
    logic       obs_ol  [3];
    logic [2:0] obs_oc  [3];
    logic       obs_ov  [3];
    logic       obs_st  [3];

    logic [3:0] a_rdy, b_rdy;
    logic [4:0] c_rdy;
    logic [3:0] a_od, b_od, c_od;
    logic       a_ol, b_ol, c_ol;
    logic [1:0] a_oc, b_oc;
    logic [2:0] c_oc;
    logic       a_ov, b_ov, c_ov;
    logic       a_st, b_st, c_st;

    mux_n_input_stream #(.WIDTH(4), .N(4), .MODE(0)) u_a (
        .clk(clk), .reset_n(rst_n),
        .in_data(d_i[0][15:0]), .in_valid(v_i[0][3:0]), .in_last(l_i[0][3:0]),
        .in_ready(a_rdy), .sel(s_i[0][1:0]),
        .out_data(a_od), .out_last(a_ol), .out_chan(a_oc), .out_valid(a_ov),
        .out_ready(ordy_i[0]), .dbg_state(a_st)
    );

    mux_n_input_stream #(.WIDTH(4), .N(4), .MODE(1)) u_b (
        .clk(clk), .reset_n(rst_n),
        .in_data(d_i[1][15:0]), .in_valid(v_i[1][3:0]), .in_last(l_i[1][3:0]),
        .in_ready(b_rdy), .sel(s_i[1][1:0]),
        .out_data(b_od), .out_last(b_ol), .out_chan(b_oc), .out_valid(b_ov),
        .out_ready(ordy_i[1]), .dbg_state(b_st)
    );

    mux_n_input_stream #(.WIDTH(4), .N(5), .MODE(0)) u_c (
        .clk(clk), .reset_n(rst_n),
        .in_data(d_i[2]), .in_valid(v_i[2]), .in_last(l_i[2]),
        .in_ready(c_rdy), .sel(s_i[2]),
        .out_data(c_od), .out_last(c_ol), .out_chan(c_oc), .out_valid(c_ov),
        .out_ready(ordy_i[2]), .dbg_state(c_st)
    );

    assign obs_rdy[0] = {1'b0, a_rdy};
    assign obs_rdy[1] = {1'b0, b_rdy};
    assign obs_rdy[2] = c_rdy;
    assign obs_od[0]  = a_od;
    assign obs_od[1]  = b_od;
    assign obs_od[2]  = c_od;
    assign obs_ol[0]  = a_ol;
    assign obs_ol[1]  = b_ol;
    assign obs_ol[2]  = c_ol;
    assign obs_oc[0]  = {1'b0, a_oc};
    assign obs_oc[1]  = {1'b0, b_oc};
    assign obs_oc[2]  = c_oc;
    assign obs_ov[0]  = a_ov;
    assign obs_ov[1]  = b_ov;
    assign obs_ov[2]  = c_ov;
    assign obs_st[0]  = a_st;
    assign obs_st[1]  = b_st;
    assign obs_st[2]  = c_st;

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    int m_ov   [3];
    int m_od   [3];
    int m_ol   [3];
    int m_oc   [3];
    int m_lock [3];   // -1 = no packet in progress
    int m_ptr  [3];   // channel that most recently finished a packet

    function automatic int pn(int k);
        return (k == 2) ? 5 : 4;
    endfunction

    function automatic int pmode(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    task automatic check(string tag, int obs, int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int mgrant(int k);
        int n;
        n = pn(k);
        if (m_lock[k] >= 0) return m_lock[k];
        if (pmode(k) == 0) return (int'(s_i[k]) < n) ? int'(s_i[k]) : -1;
        for (int j = 1; j <= n; j++) begin
            int c;
            c = (m_ptr[k] + j) % n;
            if (v_i[k][c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_rdy(int k);
        int g;
        if (!rst_n) return 0;
        g = mgrant(k);
        if (g >= 0 && (m_ov[k] == 0 || ordy_i[k])) return 1 << g;
        return 0;
    endfunction

    task automatic model_reset(int k);
        m_ov[k] = 0; m_od[k] = 0; m_ol[k] = 0; m_oc[k] = 0;
        m_lock[k] = -1; m_ptr[k] = pn(k) - 1;
    endtask

    task automatic step_model(int k);
        int g;
        int lst;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        g = mgrant(k);
        if (g >= 0 && (m_ov[k] == 0 || ordy_i[k]) && v_i[k][g]) begin
            lst     = int'(l_i[k][g]);
            m_ov[k] = 1;
            m_od[k] = int'((d_i[k] >> (4 * g)) & 20'hF);
            m_ol[k] = lst;
            m_oc[k] = g;
            if (m_lock[k] < 0 && lst == 0) m_lock[k] = g;
            else if (m_lock[k] >= 0 && lst == 1) m_lock[k] = -1;
            if (pmode(k) == 1 && lst == 1) m_ptr[k] = g;
        end else if (m_ov[k] == 1 && ordy_i[k]) begin
            m_ov[k] = 0;
        end
    endtask

    // This task is called at a negedge with the inputs already set up. It checks
    // in_ready, takes one rising edge, then checks the registered outputs.
    task automatic cycle();
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("k%0d.in_ready", k), int'(obs_rdy[k]), exp_rdy(k));
        @(posedge clk);
        for (int k = 0; k < 3; k++) step_model(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d.out_valid", k), int'(obs_ov[k]), m_ov[k]);
            check($sformatf("k%0d.state", k), int'(obs_st[k]), (m_lock[k] >= 0) ? 1 : 0);
            if (m_ov[k] == 1) begin
                check($sformatf("k%0d.out_data", k), int'(obs_od[k]), m_od[k]);
                check($sformatf("k%0d.out_last", k), int'(obs_ol[k]), m_ol[k]);
                check($sformatf("k%0d.out_chan", k), int'(obs_oc[k]), m_oc[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            v_i[k] = '0; l_i[k] = '0; d_i[k] = '0; s_i[k] = '0; ordy_i[k] = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seq36 [5];
        seq36 = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 3; k++) model_reset(k);
        idle_all();
        v_i[0] = 5'b01111; v_i[1] = 5'b01111; v_i[2] = 5'b11111;  // ready must stay 0 in reset
        rst_n = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst.k%0d.ov", k), int'(obs_ov[k]), 0);
            check($sformatf("rst.k%0d.od", k), int'(obs_od[k]), 0);
            check($sformatf("rst.k%0d.oc", k), int'(obs_oc[k]), 0);
            check($sformatf("rst.k%0d.ol", k), int'(obs_ol[k]), 0);
            check($sformatf("rst.k%0d.rdy", k), int'(obs_rdy[k]), 0);
        end
        idle_all();
        rst_n = 1'b1;
        cycle();

        // Single beat selected by sel=2.
        s_i[0] = 3'd2; v_i[0] = 5'b00100; d_i[0] = 20'h00A00; l_i[0] = 5'b00100;
        cycle();
        check("sel2.ov", int'(obs_ov[0]), 1);
        check("sel2.od", int'(obs_od[0]), 10);
        check("sel2.oc", int'(obs_oc[0]), 2);
        check("sel2.rdy", int'(obs_rdy[0]), 4);

        // Lock on ch1 survives sel moving to ch3.
        idle_all();
        s_i[0] = 3'd1; v_i[0] = 5'b00010; d_i[0] = 20'h00050;
        cycle();
        check("lock.b1.oc", int'(obs_oc[0]), 1);
        check("lock.b1.st", int'(obs_st[0]), 1);
        s_i[0] = 3'd3; v_i[0] = 5'b01010; d_i[0] = 20'h09060; l_i[0] = 5'b01000;
        cycle();
        check("lock.b2.oc", int'(obs_oc[0]), 1);
        check("lock.b2.od", int'(obs_od[0]), 6);
        l_i[0] = 5'b00010; d_i[0] = 20'h09070;
        cycle();
        check("lock.b3.oc", int'(obs_oc[0]), 1);
        check("lock.b3.od", int'(obs_od[0]), 7);
        check("lock.b3.ol", int'(obs_ol[0]), 1);
        check("lock.b3.st", int'(obs_st[0]), 0);
        v_i[0] = 5'b01000; l_i[0] = 5'b01000;
        cycle();
        check("lock.ch3.oc", int'(obs_oc[0]), 3);
        check("lock.ch3.od", int'(obs_od[0]), 9);

        // Round robin over four always-valid single-beat channels.
        idle_all();
        v_i[1] = 5'b01111; l_i[1] = 5'b01111; d_i[1] = 20'h04321;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("rr.%0d.oc", i), int'(obs_oc[1]), seq36[i]);
            check($sformatf("rr.%0d.ov", i), int'(obs_ov[1]), 1);
        end

        // Backpressure: the held ch0 beat stays put and no channel is ready.
        ordy_i[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("bp.%0d.od", i), int'(obs_od[1]), 1);
            check($sformatf("bp.%0d.oc", i), int'(obs_oc[1]), 0);
            check($sformatf("bp.%0d.rdy", i), int'(obs_rdy[1]), 0);
        end
        ordy_i[1] = 1'b1;
        #1;
        check("bp.release.rdy", int'(obs_rdy[1]), 2);
        cycle();
        check("bp.reload.ov", int'(obs_ov[1]), 1);
        check("bp.reload.oc", int'(obs_oc[1]), 1);
        check("bp.reload.od", int'(obs_od[1]), 2);

        // Reset while locked on ch2, then round robin restarts at ch0.
        v_i[1] = 5'b00100; l_i[1] = 5'b00000;
        cycle();
        check("rstmid.lock.oc", int'(obs_oc[1]), 2);
        check("rstmid.lock.st", int'(obs_st[1]), 1);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("rstmid.ov", int'(obs_ov[1]), 0);
        check("rstmid.st", int'(obs_st[1]), 0);
        rst_n = 1'b1;
        v_i[1] = 5'b01111; l_i[1] = 5'b01111;
        cycle();
        check("rstmid.next.oc", int'(obs_oc[1]), 0);

        // N=5: sel=5 names no channel; sel=4 is the highest real channel.
        idle_all();
        s_i[2] = 3'd5; v_i[2] = 5'b11111; l_i[2] = 5'b11111; d_i[2] = 20'hB0000;
        cycle();
        check("sel5.rdy", int'(obs_rdy[2]), 0);
        check("sel5.ov", int'(obs_ov[2]), 0);
        cycle();
        check("sel5.ov2", int'(obs_ov[2]), 0);
        s_i[2] = 3'd4;
        cycle();
        check("sel4.oc", int'(obs_oc[2]), 4);
        check("sel4.od", int'(obs_od[2]), 11);

        // Randomized traffic with backpressure, invalid selects and resets.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 3; k++) begin
                v_i[k]    = 5'($urandom_range(0, 31)) & ((k == 2) ? 5'h1F : 5'h0F);
                l_i[k]    = 5'($urandom_range(0, 31));
                d_i[k]    = 20'($urandom);
                s_i[k]    = (k == 2) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                ordy_i[k] = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 79) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
